stream_unpack: RTL and testbench

STREAM_UNPACK -- requirements
Module: stream_unpack

---
 rtl/stream_pkg.sv | 15 +
 rtl/word_fifo.sv | 53 +++++
 rtl/stream_unpack.sv | 109 ++++++++++
 tb/tb_stream_unpack.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared widths, lane geometry and FSM encoding for the stream unpacker.
package stream_pkg;
  localparam int WORD_W     = 64;
  localparam int LANE_W     = 16;
  localparam int LANES      = 4;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [LANES-1:0][LANE_W-1:0] word_t;
endpackage

// File: rtl/word_fifo.sv
// Show-ahead word FIFO with wrapping pointers, occupancy count and synchronous flush.
module word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/stream_unpack.sv
// Splits a frame of 64-bit words into 16-bit samples, lane 0 first, with a word FIFO in front.
module stream_unpack
  import stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       frame_words,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [LANE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);
  state_t                state;
  logic [15:0]           frame_len, word_cnt;
  word_t                 out_reg, fifo_head;
  logic                  out_valid, zero_done;
  logic [LANE_IDX_W-1:0] lane;
  logic                  fifo_full, fifo_empty;
  logic                  din_xfer, dout_xfer, last_lane, load, frame_end;

  assign din_ready  = (state == RUN) && !fifo_full;
  assign din_xfer   = din_valid && din_ready;
  assign dout_xfer  = out_valid && dout_ready;
  assign last_lane  = lane == LANE_IDX_W'(LANES-1);
  // Refill when the register is empty or its last lane leaves this cycle, so no bubble.
  assign load       = !fifo_empty && (!out_valid || (dout_xfer && last_lane));
  assign frame_end  = (state == DRAIN) && dout_xfer && last_lane && fifo_empty;

  assign dout       = out_reg[lane];
  assign dout_valid = out_valid;
  assign busy       = state != IDLE;
  assign done       = zero_done || (frame_end && !abort);

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (din_xfer),
    .wdata (din),
    .pop   (load && !abort),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_len <= '0;
      word_cnt  <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      lane      <= '0;
      zero_done <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      word_cnt  <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      lane      <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (frame_words == 16'd0) begin
              zero_done <= 1'b1;
            end else begin
              state     <= RUN;
              frame_len <= frame_words;
              word_cnt  <= '0;
            end
          end
        end
        RUN: begin
          if (din_xfer) begin
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt + 16'd1 == frame_len) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (frame_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        out_reg   <= fifo_head;
        out_valid <= 1'b1;
        lane      <= '0;
      end else if (dout_xfer) begin
        lane <= lane + LANE_IDX_W'(1);
        if (last_lane) out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_unpack.sv
// Self-checking bench: cycle table for the basic frame, directed corner sequences, random frames vs a sample-queue model.
module tb_stream_unpack;
  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] frame_words;
  logic [63:0] din;
  logic        din_valid, din_ready;
  logic [15:0] dout;
  logic        dout_valid, dout_ready, busy, done;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [63:0] words[$];

  typedef struct {
    logic        start;
    logic [15:0] fwords;
    logic [63:0] din;
    logic        dvin;
    logic        drdy;
    logic        e_dr;
    logic        e_dv;
    logic [15:0] e_dout;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  always #5 clk = ~clk;

  stream_unpack #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .frame_words (frame_words),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Drives one frame from 'words'; expected samples come from splitting each word into 16-bit lanes.
  task automatic run_frame(input int vpct, input int rpct, input int hold,
                           output int acc_hold, output logic dr_hold);
    logic [15:0] exp_q[$];
    logic [63:0] w;
    logic [15:0] stall_val;
    logic        stall, exp_done;
    int n, wi, got, cyc;
    n = words.size();
    foreach (words[i])
      for (int l = 0; l < 4; l++) begin
        w = words[i] >> (16 * l);
        exp_q.push_back(w[15:0]);
      end
    acc_hold = 0; dr_hold = 1'b0; wi = 0; got = 0; cyc = 0; stall = 1'b0; stall_val = '0;
    start = 1'b1; frame_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (got < 4 * n && cyc < 3000) begin
      din_valid  = (wi < n) && ($urandom_range(99) < vpct);
      din        = (wi < n) ? words[wi] : 64'd0;
      dout_ready = (cyc >= hold) && ($urandom_range(99) < rpct);
      #2;
      if (hold > 0 && cyc == hold) begin acc_hold = wi; dr_hold = din_ready; end
      if (stall) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_dout", dout, stall_val);
      end
      if (dout_valid && dout_ready) begin
        chk("sample", dout, exp_q[got]);
        got++;
      end
      exp_done = dout_valid && dout_ready && (got == 4 * n);
      chk("done", done, exp_done);
      if (din_valid && din_ready) wi++;
      stall = dout_valid && !dout_ready;
      stall_val = dout;
      @(posedge clk); #1;
      cyc++;
    end
    chk("frame_complete", got, 4 * n);
    din_valid = 1'b0; dout_ready = 1'b0;
    #2;
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [63:0] w0, w1, w;
    int          acc, wi, got, cyc;
    logic        drh;

    w0 = 64'h0004_0003_0002_0001;
    w1 = 64'h0008_0007_0006_0005;
    tbl[0]  = '{1'b1, 16'd2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'd2, w0,    1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'd2, w1,    1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[3+k] = '{1'b0, 16'd2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'(k + 1), 1'b1, (k == 7)};
    tbl[11] = '{1'b0, 16'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_words = '0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-word frame, one row per cycle
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start; frame_words = tbl[i].fwords; din = tbl[i].din;
      din_valid = tbl[i].dvin; dout_ready = tbl[i].drdy;
      #2;
      chk($sformatf("tbl%0d_din_ready", i), din_ready, tbl[i].e_dr);
      chk($sformatf("tbl%0d_dout_valid", i), dout_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      @(posedge clk); #1;
    end

    // Zero-length frame
    start = 1'b1; frame_words = 16'd0;
    #2;
    chk("zero_done_early", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    #2;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_din_ready", din_ready, 0);
    @(posedge clk); #1;
    chk("zero_done_end", done, 0);
    chk("zero_busy_end", busy, 0);

    // Backpressure: sink stalled, 8-word frame
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back({$urandom, $urandom});
    run_frame(100, 100, 12, acc, drh);
    chk("bp_accepted", acc, 5);
    chk("bp_din_ready", drh, 0);

    // Basic data with random sink stalls
    words.delete();
    words.push_back(w0); words.push_back(w1);
    run_frame(100, 50, 0, acc, drh);

    // Abort after three samples of a four-word frame
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back({$urandom, $urandom});
    start = 1'b1; frame_words = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; wi = 0; got = 0; cyc = 0;
    while (got < 3 && cyc < 200) begin
      din_valid = wi < 4;
      din = (wi < 4) ? words[wi] : 64'd0;
      dout_ready = 1'b1;
      #2;
      if (dout_valid && dout_ready) begin
        w = words[got / 4] >> (16 * (got % 4));
        chk("abort_pre_sample", dout, w[15:0]);
        got++;
      end
      if (din_valid && din_ready) wi++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_pre_count", got, 3);
    abort = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    #2;
    chk("abort_cycle_done", done, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    #2;
    chk("abort_dout_valid", dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_din_ready", din_ready, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    chk("abort_done_late", done, 0);
    words.delete();
    words.push_back({$urandom, $urandom});
    run_frame(100, 100, 0, acc, drh);

    // Reset asserted while draining
    words.delete();
    words.push_back({$urandom, $urandom}); words.push_back({$urandom, $urandom});
    start = 1'b1; frame_words = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; wi = 0; cyc = 0; dout_ready = 1'b0;
    while (wi < 2 && cyc < 50) begin
      din_valid = 1'b1; din = words[wi];
      #2;
      if (din_ready) wi++;
      @(posedge clk); #1;
      cyc++;
    end
    din_valid = 1'b0;
    #2;
    chk("rmid_fed", wi, 2);
    chk("rmid_busy_pre", busy, 1);
    chk("rmid_din_ready_pre", din_ready, 0);
    rst_n = 1'b0; start = 1'b1; frame_words = 16'd1;
    #1;
    chk("rmid_dout_valid", dout_valid, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_din_ready", din_ready, 0);
    chk("rmid_done", done, 0);
    chk("rmid_dout", dout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    #2;
    chk("rmid_busy_release", busy, 0);
    @(posedge clk); #1;
    chk("rmid_busy_after", busy, 0);
    chk("rmid_dout_valid_after", dout_valid, 0);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) words.push_back({$urandom, $urandom});
      run_frame(int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), 0, acc, drh);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
